pixel_stream_tx: RTL and testbench
==================================

// Module: pixel_stream_tx
// PURPOSE
//  Transmitter side of the pixel-stream interface consumed by the detection pipeline (rgb2i/Sobel/CCL).
//  Pulls pixels from a valid/ready source (frame reader or bench memory) and drives en/data plus
//  single-cycle hsync/vsync markers with programmable blanking. Sits directly upstream of the pipeline top.
// PARAMETERS
//  PIXEL_W      24   pixel width (matches `PIXEL_SIZE): {B[23:16],G[15:8],R[7:0]}
//  FRAME_WIDTH  550  active pixels per row, >=1
//  FRAME_HEIGHT 1    rows per frame, >=1
//  H_BLANK      4    idle cycles after each hsync, >=0
//  V_BLANK      16   idle cycles after each vsync, >=0
// PORTS
//  clk           in   1        sole clock, rising edge
//  reset         in   1        synchronous, active-high
//  start         in   1        level; frame begins/continues while high
//  src_valid     in   1        source pixel available
//  src_data      in   PIXEL_W  source pixel
//  src_ready     out  1        transmitter accepts pixel this cycle
//  pattern_en    in   1        select internal test pattern (see CONFIGURATION)
//  en            out  1        data carries a valid active pixel
//  hsync         out  1        one-cycle row-end marker
//  vsync         out  1        one-cycle frame-end marker
//  data          out  PIXEL_W  pixel
//  busy          out  1        state != IDLE
//  frame_count   out  16       completed frames, wraps 0xFFFF->0
//  underrun_cnt  out  16       stall cycles in ACTIVE, saturates at 0xFFFF
// BEHAVIOUR
//  - Reset: state IDLE, x=y=0; en/hsync/vsync/data/busy/frame_count/underrun_cnt = 0. Reset mid-frame aborts
//    immediately; no partial markers emitted afterwards.
//  - FSM: IDLE -> ACTIVE when start=1. ACTIVE: src_ready=1; accept on src_valid&src_ready; x++.
//    After pixel FRAME_WIDTH-1 accepted: if y<FRAME_HEIGHT-1 -> HSYNC else -> VSYNC.
//    HSYNC (1 cycle): y++, x=0 -> HBLANK (or ACTIVE if H_BLANK=0). HBLANK: H_BLANK cycles -> ACTIVE.
//    VSYNC (1 cycle): y=0, x=0, frame_count++ -> VBLANK (or next state directly if V_BLANK=0).
//    VBLANK end: start=1 -> ACTIVE, else IDLE. start is sampled only in IDLE and at VBLANK end.
//  - src_ready is combinational: (state==ACTIVE) && !pattern mode; zero elsewhere.
//  - All stream outputs registered: accepted pixel appears on data with en=1 exactly 1 cycle later;
//    hsync/vsync asserted 1 cycle after the HSYNC/VSYNC state cycle, so they follow the row's last en cycle back-to-back.
//  - en, hsync, vsync mutually exclusive. data holds last pixel whenever en=0.
//  - Underrun: ACTIVE with src_valid=0 -> en=0 next cycle, x unchanged, underrun_cnt++ (saturating).
//  - Last row gets vsync only (no hsync). FRAME_HEIGHT=1 -> no hsync ever.
//  - Cycles per frame with no underrun: FRAME_HEIGHT*FRAME_WIDTH + (FRAME_HEIGHT-1)*(1+H_BLANK) + 1 + V_BLANK.
//  - x,y are 16-bit internally; FRAME_WIDTH/HEIGHT <= 65535.
// CONFIGURATION
//  PIXEL_TX_PATTERN_EN defined: when pattern_en=1 (sampled at ACTIVE entry, held for whole frame) source is
//    ignored (src_ready=0) and data = {y[7:0], x[7:0], frame_count[7:0]}, never underruns.
//  Undefined: pattern_en ignored; generator logic absent; behaviour identical to pattern_en=0.
// TESTING (FRAME_WIDTH=4, FRAME_HEIGHT=2, H_BLANK=2, V_BLANK=3 unless stated)
//  1 start=1 one cycle, src always valid, pixels 0x000001..0x000008 -> en x4 (01..04), hsync, 2 idle,
//    en x4 (05..08), vsync, 3 idle, IDLE; 15 cycles; frame_count=1; underrun_cnt=0.
//  2 start held high, 3 frames -> back-to-back frames, 45 cycles total, frame_count=3, busy never drops.
//  3 src_valid=0 for 3 cycles mid-row 1 -> 3 en=0 gaps, no pixel lost/duplicated, underrun_cnt=3,
//    hsync still directly after 4th pixel.
//  4 reset=1 during row 2 pixel 2 -> next cycle all outputs 0, busy=0; restart yields clean frame as test 1.
//  5 H_BLANK=0, V_BLANK=0, FRAME_HEIGHT=1 -> en x4, vsync, en x4 (start high), no hsync ever.
//  6 PIXEL_TX_PATTERN_EN defined, pattern_en=1 -> src_ready=0; row1 data 0x000000,0x000100,0x000200,0x000300;
//    row2 0x010000..0x010300; second frame low byte 0x01.

Source files
------------

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: pulls pixels from a valid/ready source and drives a registered
// en/data stream with one-cycle hsync (row end) and vsync (frame end) markers,
// followed by programmable horizontal/vertical blanking.
// Optional feature macro: PIXEL_TX_PATTERN_EN adds an internal test-pattern
// generator selected by pattern_en; without it pattern_en is ignored.
module pixel_stream_tx #(
  parameter int PIXEL_W      = 24,
  parameter int FRAME_WIDTH  = 550,
  parameter int FRAME_HEIGHT = 1,
  parameter int H_BLANK      = 4,
  parameter int V_BLANK      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               src_valid,
  input  logic [PIXEL_W-1:0] src_data,
  output logic               src_ready,
  input  logic               pattern_en,
  output logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic [PIXEL_W-1:0] data,
  output logic               busy,
  output logic [15:0]        frame_count,
  output logic [15:0]        underrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_HSYNC,
    S_HBLANK,
    S_VSYNC,
    S_VBLANK
  } state_t;

  localparam logic [15:0] X_LAST  = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] Y_LAST  = 16'(FRAME_HEIGHT - 1);
  localparam logic [15:0] HB_LAST = 16'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [15:0] VB_LAST = 16'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  state_t               state_reg, state_next;
  logic [15:0]          x_reg, y_reg, blank_reg;
  logic                 en_reg, hsync_reg, vsync_reg;
  logic [PIXEL_W-1:0]   data_reg;
  logic [15:0]          frame_count_reg, underrun_cnt_reg;
  logic                 advance;
  logic                 frame_start;
  logic                 pattern_mode;
  logic [PIXEL_W-1:0]   pixel_in;

  // A frame begins whenever ACTIVE is entered from outside a frame (not after an hsync).
  assign frame_start = (state_next == S_ACTIVE) &&
                       ((state_reg == S_IDLE) || (state_reg == S_VBLANK) || (state_reg == S_VSYNC));

`ifdef PIXEL_TX_PATTERN_EN
  logic pattern_reg;

  // Latch the pattern selection once per frame so a frame is never mixed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reg <= 1'b0;
    end else if (frame_start) begin
      pattern_reg <= pattern_en;
    end
  end

  assign pattern_mode = pattern_reg;
  assign pixel_in     = pattern_mode ? PIXEL_W'({y_reg[7:0], x_reg[7:0], frame_count_reg[7:0]})
                                     : src_data;
`else
  logic unused_pattern_en;

  assign unused_pattern_en = pattern_en;
  assign pattern_mode      = 1'b0;
  assign pixel_in          = src_data;
`endif

  // Next-state logic; a pixel advances on a handshake or, in pattern mode, every ACTIVE cycle.
  always_comb begin
    state_next = state_reg;
    src_ready  = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        src_ready = !pattern_mode;
        advance   = pattern_mode || src_valid;
        if (advance && (x_reg == X_LAST)) begin
          state_next = (y_reg == Y_LAST) ? S_VSYNC : S_HSYNC;
        end
      end
      S_HSYNC: begin
        state_next = (H_BLANK == 0) ? S_ACTIVE : S_HBLANK;
      end
      S_HBLANK: begin
        if (blank_reg == HB_LAST) state_next = S_ACTIVE;
      end
      S_VSYNC: begin
        if (V_BLANK == 0) state_next = start ? S_ACTIVE : S_IDLE;
        else              state_next = S_VBLANK;
      end
      S_VBLANK: begin
        if (blank_reg == VB_LAST) state_next = start ? S_ACTIVE : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Pixel position and blanking counters; blanking states are never back-to-back, so the counter restarts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg     <= '0;
      y_reg     <= '0;
      blank_reg <= '0;
    end else begin
      blank_reg <= ((state_reg == S_HBLANK) || (state_reg == S_VBLANK)) ? blank_reg + 16'd1 : 16'd0;
      if (advance) begin
        x_reg <= (x_reg == X_LAST) ? 16'd0 : x_reg + 16'd1;
      end
      if (state_reg == S_HSYNC) begin
        y_reg <= y_reg + 16'd1;
        x_reg <= '0;
      end
      if (state_reg == S_VSYNC) begin
        y_reg <= '0;
        x_reg <= '0;
      end
    end
  end

  // Registered stream outputs; data holds the last pixel whenever en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg    <= 1'b0;
      hsync_reg <= 1'b0;
      vsync_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      en_reg    <= advance;
      hsync_reg <= (state_reg == S_HSYNC);
      vsync_reg <= (state_reg == S_VSYNC);
      if (advance) data_reg <= pixel_in;
    end
  end

  // Status counters: completed frames wrap, source stalls in ACTIVE saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_reg  <= '0;
      underrun_cnt_reg <= '0;
    end else begin
      if (state_reg == S_VSYNC) frame_count_reg <= frame_count_reg + 16'd1;
      if ((state_reg == S_ACTIVE) && !pattern_mode && !src_valid && (underrun_cnt_reg != 16'hFFFF)) begin
        underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
      end
    end
  end

  assign en           = en_reg;
  assign hsync        = hsync_reg;
  assign vsync        = vsync_reg;
  assign data         = data_reg;
  assign busy         = (state_reg != S_IDLE);
  assign frame_count  = frame_count_reg;
  assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: drives two transmitter configurations (4x2 with blanking,
// 4x1 without blanking) from one shared stimulus and compares every output
// against a frame-timeline reference model.
module tb_pixel_stream_tx;

  localparam int PW    = 24;
  localparam int NI    = 2;
  localparam int K_PIX = 0;
  localparam int K_HS  = 1;
  localparam int K_VS  = 2;
  localparam int K_BL  = 3;

  // Geometry of each instance: width, height, h-blank, v-blank.
  int cfg_w  [NI] = '{4, 4};
  int cfg_h  [NI] = '{2, 1};
  int cfg_hb [NI] = '{2, 0};
  int cfg_vb [NI] = '{3, 0};

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          src_valid;
  logic          pattern_en;
  logic [PW-1:0] src_data;
  logic          src_ready    [NI];
  logic          en           [NI];
  logic          hsync        [NI];
  logic          vsync        [NI];
  logic          busy         [NI];
  logic [PW-1:0] data         [NI];
  logic [15:0]   frame_count  [NI];
  logic [15:0]   underrun_cnt [NI];

  int tests = 0;
  int fails = 0;

  // Reference model state: idle flag plus position along the frame timeline.
  bit          m_idle [NI] = '{1'b1, 1'b1};
  int          m_pos  [NI] = '{0, 0};
  bit          m_pat  [NI] = '{1'b0, 1'b0};
  bit          m_en   [NI] = '{1'b0, 1'b0};
  bit          m_hs   [NI] = '{1'b0, 1'b0};
  bit          m_vs   [NI] = '{1'b0, 1'b0};
  logic [PW-1:0] m_data [NI] = '{'0, '0};
  logic [15:0] m_fc   [NI] = '{16'd0, 16'd0};
  logic [15:0] m_uc   [NI] = '{16'd0, 16'd0};

  always #5 clk = ~clk;

  pixel_stream_tx #(
    .PIXEL_W(PW), .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .H_BLANK(2), .V_BLANK(3)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready[0]), .pattern_en(pattern_en), .en(en[0]), .hsync(hsync[0]),
    .vsync(vsync[0]), .data(data[0]), .busy(busy[0]), .frame_count(frame_count[0]),
    .underrun_cnt(underrun_cnt[0])
  );

  pixel_stream_tx #(
    .PIXEL_W(PW), .FRAME_WIDTH(4), .FRAME_HEIGHT(1), .H_BLANK(0), .V_BLANK(0)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready[1]), .pattern_en(pattern_en), .en(en[1]), .hsync(hsync[1]),
    .vsync(vsync[1]), .data(data[1]), .busy(busy[1]), .frame_count(frame_count[1]),
    .underrun_cnt(underrun_cnt[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles from frame start to the next possible frame start.
  function automatic int frame_len(input int i);
    return cfg_h[i] * cfg_w[i] + (cfg_h[i] - 1) * (1 + cfg_hb[i]) + 1 + cfg_vb[i];
  endfunction

  // What happens at position p of the frame: a pixel slot, a marker, or a blank cycle.
  function automatic int ev_kind(input int i, input int p, output int x, output int y);
    int row_len;
    int r;
    int c;
    row_len = cfg_w[i] + 1 + cfg_hb[i];
    r = p / row_len;
    c = p % row_len;
    if (r >= cfg_h[i] - 1) begin
      y = cfg_h[i] - 1;
      c = p - (cfg_h[i] - 1) * row_len;
      x = c;
      if (c < cfg_w[i]) return K_PIX;
      return (c == cfg_w[i]) ? K_VS : K_BL;
    end
    y = r;
    x = c;
    if (c < cfg_w[i]) return K_PIX;
    return (c == cfg_w[i]) ? K_HS : K_BL;
  endfunction

  function automatic bit model_ready(input int i);
    int x;
    int y;
    if (m_idle[i]) return 1'b0;
    return (ev_kind(i, m_pos[i], x, y) == K_PIX) && !m_pat[i];
  endfunction

  function automatic bit sample_pattern();
`ifdef PIXEL_TX_PATTERN_EN
    return pattern_en;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step(input int i);
    int  x;
    int  y;
    int  k;
    bit  adv;
    if (reset) begin
      m_idle[i] = 1'b1;
      m_pos[i]  = 0;
      m_pat[i]  = 1'b0;
      m_en[i]   = 1'b0;
      m_hs[i]   = 1'b0;
      m_vs[i]   = 1'b0;
      m_data[i] = '0;
      m_fc[i]   = '0;
      m_uc[i]   = '0;
      return;
    end
    m_en[i] = 1'b0;
    m_hs[i] = 1'b0;
    m_vs[i] = 1'b0;
    if (m_idle[i]) begin
      if (start) begin
        m_idle[i] = 1'b0;
        m_pos[i]  = 0;
        m_pat[i]  = sample_pattern();
      end
      return;
    end
    k   = ev_kind(i, m_pos[i], x, y);
    adv = 1'b1;
    if (k == K_PIX) begin
      if (m_pat[i]) begin
        m_en[i]   = 1'b1;
        m_data[i] = PW'({8'(y), 8'(x), m_fc[i][7:0]});
      end else if (src_valid) begin
        m_en[i]   = 1'b1;
        m_data[i] = src_data;
      end else begin
        adv = 1'b0;
        if (m_uc[i] != 16'hFFFF) m_uc[i] = m_uc[i] + 16'd1;
      end
    end else if (k == K_HS) begin
      m_hs[i] = 1'b1;
    end else if (k == K_VS) begin
      m_vs[i] = 1'b1;
      m_fc[i] = m_fc[i] + 16'd1;
    end
    if (adv) begin
      m_pos[i]++;
      if (m_pos[i] == frame_len(i)) begin
        if (start) begin
          m_pos[i] = 0;
          m_pat[i] = sample_pattern();
        end else begin
          m_idle[i] = 1'b1;
        end
      end
    end
  endfunction

  // One clock: drive inputs, check src_ready, clock, then check registered outputs.
  task automatic run_cycle(input bit rst_i, input bit start_i, input bit valid_i, input bit pat_i);
    @(negedge clk);
    reset      = rst_i;
    start      = start_i;
    src_valid  = valid_i;
    pattern_en = pat_i;
    src_data   = PW'($urandom);
    #1;
    if (!rst_i) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("src_ready%0d", i), 32'(src_ready[i]), 32'(model_ready(i)));
      end
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("en%0d", i),           32'(en[i]),           32'(m_en[i]));
      check($sformatf("hsync%0d", i),        32'(hsync[i]),        32'(m_hs[i]));
      check($sformatf("vsync%0d", i),        32'(vsync[i]),        32'(m_vs[i]));
      check($sformatf("data%0d", i),         32'(data[i]),         32'(m_data[i]));
      check($sformatf("busy%0d", i),         32'(busy[i]),         32'(!m_idle[i]));
      check($sformatf("frame_count%0d", i),  32'(frame_count[i]),  32'(m_fc[i]));
      check($sformatf("underrun_cnt%0d", i), 32'(underrun_cnt[i]), 32'(m_uc[i]));
    end
  endtask

  initial begin
    int busy_cycles;
    int fc_base;
    int uc_base;
    bit v;

    reset      = 1'b1;
    start      = 1'b0;
    src_valid  = 1'b0;
    pattern_en = 1'b0;
    src_data   = '0;
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Single start pulse, source always valid: one frame then back to idle.
    busy_cycles = 0;
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    busy_cycles += int'(busy[0]);
    repeat (24) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
      busy_cycles += int'(busy[0]);
    end
    check("t1_busy_cycles", 32'(busy_cycles), 32'(frame_len(0)));
    check("t1_frame_count", 32'(frame_count[0]), 32'd1);

    // Start held high: three back-to-back frames with busy never dropping.
    fc_base     = int'(frame_count[0]);
    busy_cycles = 0;
    repeat (3 * frame_len(0)) begin
      run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      busy_cycles += int'(busy[0]);
    end
    check("t2_busy_cycles", 32'(busy_cycles), 32'(3 * frame_len(0)));
    check("t2_frames", 32'(int'(frame_count[0]) - fc_base), 32'd3);
    repeat (20) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // Three stalled source cycles in the middle of the first row.
    uc_base = int'(underrun_cnt[0]);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 25; c++) begin
      v = !(c >= 2 && c <= 4);
      run_cycle(1'b0, 1'b0, v, 1'b0);
    end
    check("t3_underruns", 32'(int'(underrun_cnt[0]) - uc_base), 32'd3);

    // Reset during the second row, then a clean frame.
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (8) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_busy_after_reset", 32'(busy[0]), 32'd0);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_frame_count", 32'(frame_count[0]), 32'd1);

    // Randomized traffic: stalls, start toggling, occasional resets, pattern requests.
    for (int n = 0; n < 3000; n++) begin
      run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
